// File: rtl/e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// e_mdu_ctrl
//   Multi-cycle multiply/divide unit for the E stage. It owns the
//   architectural HI/LO registers. The full result of an operation is
//   computed on issue and held in pending registers. It is committed to
//   HI/LO only when the configured latency has elapsed, so HI/LO keep their
//   old values while the unit is busy.
//
// Ports
//   clk      : clock, all state updates on the rising edge
//   reset    : asynchronous, active-low reset
//   start    : E-stage instruction is an MDU op (qualifies op)
//   op       : 001 mult, 010 multu, 011 div, 100 divu, 101 mthi, 110 mtlo,
//              000/111 no operation
//   dataA    : rs operand (dividend / multiplicand / mthi-mtlo source)
//   dataB    : rt operand (divisor / multiplier)
//   rd_sel   : 0 selects LO, 1 selects HI onto rd_data
//   d_md     : D-stage instruction touches HI/LO or the MDU
//   busy     : multi-cycle operation in progress
//   stall    : stall request to the D stage / hazard unit
//   hi, lo   : committed architectural HI and LO
//   rd_data  : rd_sel ? hi : lo (combinational)
// ---------------------------------------------------------------------------
module e_mdu_ctrl #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] dataA,
    input  logic [31:0] dataB,
    input  logic        rd_sel,
    input  logic        d_md,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] rd_data
);

    localparam logic [2:0] OP_MULT  = 3'b001;
    localparam logic [2:0] OP_MULTU = 3'b010;
    localparam logic [2:0] OP_DIV   = 3'b011;
    localparam logic [2:0] OP_DIVU  = 3'b100;
    localparam logic [2:0] OP_MTHI  = 3'b101;
    localparam logic [2:0] OP_MTLO  = 3'b110;

    // The counter is 8 bits; both latencies must lie in 1..255.
    localparam logic [7:0] MULT_CNT = 8'(MULT_CYCLES);
    localparam logic [7:0] DIV_CNT  = 8'(DIV_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MULT = 2'd1,
        ST_DIV  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic        busy_q, busy_d;
    logic [31:0] hi_q, hi_d;
    logic [31:0] lo_q, lo_d;
    logic [31:0] pend_hi_q, pend_hi_d;
    logic [31:0] pend_lo_q, pend_lo_d;
    logic        pend_wr_q, pend_wr_d;

    logic        is_mul;
    logic        is_div;
    logic [63:0] mul_res;
    logic [63:0] div_res;

    // 32x32 -> 64 product, signed or unsigned.
    function automatic logic [63:0] mdu_mul(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
        logic signed [63:0] sa;
        logic signed [63:0] sb;
        logic        [63:0] ua;
        logic        [63:0] ub;
        sa = {{32{a[31]}}, a};
        sb = {{32{b[31]}}, b};
        ua = {32'd0, a};
        ub = {32'd0, b};
        if (sgn) return sa * sb;
        else     return ua * ub;
    endfunction

    // Returns {remainder, quotient}. Signed division works on magnitudes:
    // the quotient truncates toward zero and the remainder takes the sign of
    // the dividend. 0x80000000 / -1 falls out naturally as quotient
    // 0x80000000, remainder 0. A zero divisor yields a don't-care value.
    function automatic logic [63:0] mdu_div(input logic [31:0] a,
                                            input logic [31:0] b,
                                            input logic        sgn);
        logic        neg_a;
        logic        neg_b;
        logic [31:0] mag_a;
        logic [31:0] mag_b;
        logic [31:0] quo;
        logic [31:0] rem;
        neg_a = sgn & a[31];
        neg_b = sgn & b[31];
        mag_a = neg_a ? (32'd0 - a) : a;
        mag_b = neg_b ? (32'd0 - b) : b;
        quo   = (mag_b == 32'd0) ? 32'd0 : (mag_a / mag_b);
        rem   = (mag_b == 32'd0) ? 32'd0 : (mag_a % mag_b);
        if (neg_a ^ neg_b) quo = 32'd0 - quo;
        if (neg_a)         rem = 32'd0 - rem;
        return {rem, quo};
    endfunction

    assign is_mul  = start & ((op == OP_MULT) | (op == OP_MULTU));
    assign is_div  = start & ((op == OP_DIV)  | (op == OP_DIVU));
    assign mul_res = mdu_mul(dataA, dataB, op == OP_MULT);
    assign div_res = mdu_div(dataA, dataB, op == OP_DIV);

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        busy_d    = busy_q;
        hi_d      = hi_q;
        lo_d      = lo_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;

        case (state_q)
            ST_IDLE: begin
                if (is_mul) begin
                    pend_hi_d = mul_res[63:32];
                    pend_lo_d = mul_res[31:0];
                    pend_wr_d = 1'b1;
                    cnt_d     = MULT_CNT;
                    busy_d    = 1'b1;
                    state_d   = ST_MULT;
                end else if (is_div) begin
                    pend_hi_d = div_res[63:32];
                    pend_lo_d = div_res[31:0];
                    // Divide by zero still occupies the unit but leaves HI/LO alone.
                    pend_wr_d = (dataB != 32'd0);
                    cnt_d     = DIV_CNT;
                    busy_d    = 1'b1;
                    state_d   = ST_DIV;
                end else if (start && (op == OP_MTHI)) begin
                    hi_d = dataA;
                end else if (start && (op == OP_MTLO)) begin
                    lo_d = dataA;
                end
            end
            ST_MULT, ST_DIV: begin
                // Any start here is ignored; the stall logic keeps it from
                // happening in legal code.
                if (cnt_q == 8'd1) begin
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                    cnt_d   = 8'd0;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                cnt_d   = 8'd0;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 8'd0;
            busy_q    <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            pend_hi_q <= 32'd0;
            pend_lo_q <= 32'd0;
            pend_wr_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
        end
    end

    assign busy    = busy_q;
    assign hi      = hi_q;
    assign lo      = lo_q;
    assign rd_data = rd_sel ? hi_q : lo_q;
    // Includes the issue cycle, before busy has risen.
    assign stall   = d_md & (busy_q | is_mul | is_div);

endmodule

// File: tb/tb_e_mdu_ctrl.sv
// ---------------------------------------------------------------------------
// tb_e_mdu_ctrl
//   Directed and randomized bench for e_mdu_ctrl. A behavioural model keeps
//   the expected HI/LO using plain 64-bit arithmetic, and each operation's
//   busy window is checked cycle by cycle.
// ---------------------------------------------------------------------------
module tb_e_mdu_ctrl;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  op = 3'd0;
    logic [31:0] dataA = 32'd0;
    logic [31:0] dataB = 32'd0;
    logic        rd_sel = 1'b0;
    logic        d_md = 1'b0;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [31:0] rd_data;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    e_mdu_ctrl #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .dataA(dataA), .dataB(dataB), .rd_sel(rd_sel), .d_md(d_md),
        .busy(busy), .stall(stall), .hi(hi), .lo(lo), .rd_data(rd_data)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout checks=%0d", checks);
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_arch(input string tag, input logic [31:0] eh, input logic [31:0] el);
        chk({tag, "_hi"}, hi, eh);
        chk({tag, "_lo"}, lo, el);
        rd_sel = 1'b0;
        #1;
        chk({tag, "_rd_lo"}, rd_data, el);
        rd_sel = 1'b1;
        #1;
        chk({tag, "_rd_hi"}, rd_data, eh);
    endtask

    function automatic int cycles_of(input logic [2:0] o);
        if (o == 3'd1 || o == 3'd2) return MC;
        if (o == 3'd3 || o == 3'd4) return DC;
        return 0;
    endfunction

    // Reference semantics of each op on the architectural HI/LO.
    function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, q, r;
        logic [63:0] p;
        case (o)
            3'd1: begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                p = 64'(sa * sb);
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd2: begin
                p = {32'd0, a} * {32'd0, b};
                m_hi = p[63:32]; m_lo = p[31:0];
            end
            3'd3: if (b != 32'd0) begin
                sa = longint'($signed(a));
                sb = longint'($signed(b));
                q = sa / sb;
                r = sa % sb;
                m_lo = q[31:0]; m_hi = r[31:0];
            end
            3'd4: if (b != 32'd0) begin
                m_lo = a / b; m_hi = a % b;
            end
            3'd5: m_hi = a;
            3'd6: m_lo = a;
            default: ;
        endcase
    endfunction

    // Issue one op from IDLE and follow it to completion. With inject set,
    // an mtlo 0xABCD is presented during the second busy cycle.
    task automatic run_op(input string tag, input logic [2:0] o, input logic [31:0] a,
                          input logic [31:0] b, input logic dmd, input bit inject);
        logic [31:0] oh;
        logic [31:0] ol;
        int          n;
        oh = m_hi;
        ol = m_lo;
        n  = cycles_of(o);
        start = 1'b1; op = o; dataA = a; dataB = b; d_md = dmd;
        #1;
        chk1({tag, "_stall_issue"}, stall, dmd && (n > 0));
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0; dataA = $urandom; dataB = $urandom;
        ref_op(o, a, b);
        for (int k = 1; k <= n; k++) begin
            chk1({tag, "_busy"}, busy, 1'b1);
            chk1({tag, "_stall_busy"}, stall, dmd);
            chk({tag, "_hold_hi"}, hi, oh);
            chk({tag, "_hold_lo"}, lo, ol);
            if (inject && k == 2) begin
                start = 1'b1; op = 3'd6; dataA = 32'h0000ABCD;
            end else begin
                start = 1'b0; op = 3'd0;
            end
            @(posedge clk); #1;
        end
        start = 1'b0; op = 3'd0;
        #1;
        chk1({tag, "_busy_done"}, busy, 1'b0);
        chk1({tag, "_stall_done"}, stall, 1'b0);
        chk_arch(tag, m_hi, m_lo);
    endtask

    initial begin
        logic [2:0]  ro;
        logic [31:0] ra, rb;

        // Reset state
        d_md = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk1("rst_busy", busy, 1'b0);
        chk1("rst_stall", stall, 1'b0);
        chk_arch("rst", 32'd0, 32'd0);
        reset = 1'b1;
        d_md = 1'b0;
        @(posedge clk); #1;

        // Signed multiply -3 * 5
        run_op("mult", 3'd1, 32'hFFFFFFFD, 32'd5, 1'b1, 1'b0);
        chk("mult_hi_const", hi, 32'hFFFFFFFF);
        chk("mult_lo_const", lo, 32'hFFFFFFF1);

        // Unsigned multiply 0xFFFFFFFF * 2
        run_op("multu", 3'd2, 32'hFFFFFFFF, 32'd2, 1'b0, 1'b0);
        rd_sel = 1'b1; #1;
        chk("multu_rd_hi_const", rd_data, 32'h00000001);
        chk("multu_lo_const", lo, 32'hFFFFFFFE);

        // Signed divide -7 / 2
        run_op("div", 3'd3, 32'hFFFFFFF9, 32'd2, 1'b0, 1'b0);
        chk("div_lo_const", lo, 32'hFFFFFFFD);
        chk("div_hi_const", hi, 32'hFFFFFFFF);

        // Divide by zero leaves HI/LO untouched
        run_op("mthi", 3'd5, 32'h11, 32'd0, 1'b1, 1'b0);
        run_op("mtlo", 3'd6, 32'h22, 32'd0, 1'b0, 1'b0);
        run_op("divu0", 3'd4, 32'd7, 32'd0, 1'b1, 1'b0);
        chk("divu0_hi_const", hi, 32'h11);
        chk("divu0_lo_const", lo, 32'h22);

        // mtlo during busy is ignored
        run_op("mult_inj", 3'd1, $urandom, $urandom, 1'b1, 1'b1);

        // mtlo in IDLE takes effect next cycle
        run_op("mtlo_idle", 3'd6, 32'h0000ABCD, 32'd0, 1'b1, 1'b0);
        chk("mtlo_idle_const", lo, 32'h0000ABCD);

        // Signed overflow case
        run_op("div_ovf", 3'd3, 32'h80000000, 32'hFFFFFFFF, 1'b0, 1'b0);
        chk("div_ovf_lo_const", lo, 32'h80000000);
        chk("div_ovf_hi_const", hi, 32'h00000000);

        // No-op and reserved encodings
        run_op("op_none", 3'd0, $urandom, $urandom, 1'b1, 1'b0);
        run_op("op_rsvd", 3'd7, $urandom, $urandom, 1'b1, 1'b0);

        // Randomized operations
        for (int i = 0; i < 24; i++) begin
            ro = 3'($urandom_range(1, 6));
            ra = $urandom;
            rb = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($signed(3'($urandom_range(0, 7))) );
            run_op("rand", ro, ra, rb, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Reset in the fourth busy cycle of a divide
        start = 1'b1; op = 3'd3; dataA = $urandom; dataB = 32'd3; d_md = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; op = 3'd0;
        repeat (3) begin @(posedge clk); #1; end
        chk1("abort_busy_before", busy, 1'b1);
        #1;
        reset = 1'b0;
        #1;
        m_hi = 32'd0;
        m_lo = 32'd0;
        chk1("abort_busy", busy, 1'b0);
        chk1("abort_stall", stall, 1'b0);
        chk("abort_hi", hi, 32'd0);
        chk("abort_lo", lo, 32'd0);
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        chk_arch("abort_after", 32'd0, 32'd0);
        run_op("mult_after_rst", 3'd1, $urandom, $urandom, 1'b1, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
